router_input_rr: RTL and testbench
==================================

# router_input_rr

Parametrised router input stage that arbitrates among NPORTS×NVCS input flit queues, presents one selected flit per cycle to the routing pipeline, and acknowledges the source queue once the flit is routed. Compared with the static-priority input stage it replaces, it adds selectable round-robin arbitration, a configurable flit width and source-field position, and bounded same-timestep retry of flits that fail routing. It sits between the per-input flit queues and the router's stage-2 route/allocate logic.

## Interface
Parameters:
- NPORTS, 5, router ports (≥2)
- NVCS, 2, virtual channels per port (≥2)
- FLIT_WIDTH, 36, flit width in bits
- SRC_LSB, 2, LSB of the source-input field rewritten in s1_flit; field width LOG_NINPUTS = CLogB2(NPORTS-1)+CLogB2(NVCS-1)
- ARB_MODE, 1, 0 = static (lowest index wins), 1 = round-robin
- MAX_RETRY, 3, retries allowed per timestep; 0 disables retry

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- enable  in  1  pipeline advance; state holds when low
- sim_time_tick  in  1  start of new simulation timestep (synchronous clear)
- flit_in  in  NINPUTS*FLIT_WIDTH  input flits, input i at slice i
- flit_in_valid  in  NINPUTS  head-flit valid per input
- s2_flit_valid  in  1  stage-2 holds a valid flit
- s2_flit_routed  in  1  stage-2 flit routed this cycle
- s1_flit  out  FLIT_WIDTH  selected flit, source field replaced by {port, vc}; unregistered
- s1_flit_valid  out  1  a grant exists this cycle; unregistered
- s1_flit_iport  out  LOG_NINPUTS  encoded selected input; unregistered
- s2_flit_iport_decoded  out  NINPUTS  registered one-hot input of stage-2 flit
- flit_ack  out  NINPUTS  one-hot dequeue to input queue
- can_increment  out  1  timestep may advance
- retry_exhausted  out  1  retry budget used up this timestep

## Operation
- Eligible set E = flit_in_valid & ~inspected. Arbiter grants one bit of E (ARB_MODE 0: lowest index; ARB_MODE 1: first set bit at or above rr_ptr, wrapping).
- s1_flit = selected flit with bits [SRC_LSB+LOG_NINPUTS-1:SRC_LSB] = encoded input index; all other bits pass through. When E=0: s1_flit_valid=0, s1_flit_iport=0, s1_flit = flit of input 0.
- flit_ack = s2_flit_iport_decoded when s2_flit_valid & s2_flit_routed, else 0.
- Retry: when enable & s2_flit_valid & ~s2_flit_routed & retry_cnt<MAX_RETRY, clear inspected bit of s2 input and increment retry_cnt. Otherwise an unrouted flit stays inspected until the next tick.
- can_increment = (E==0) & ~s2_flit_valid.
- retry_exhausted = (retry_cnt==MAX_RETRY) with MAX_RETRY>0.

## Timing
- Reset (reset=0, async): inspected=0, s2 select=0, rr_ptr=0, retry_cnt=0. Outputs: s2_flit_iport_decoded=0, flit_ack=0, retry_exhausted=0. s1_* and can_increment follow inputs.
- s1 path is combinational from inputs and state, with zero latency. The s2 select register captures the grant on enable, one cycle later.
- Per edge with enable: inspected <= (inspected | grant) & ~retry_clear. Bits are disjoint because the grant comes from uninspected inputs.
- sim_time_tick takes priority over enable. It clears inspected and retry_cnt regardless of enable. It does not clear the s2 select register or rr_ptr.
- rr_ptr <= (granted index + 1) mod NINPUTS on enable & s1_flit_valid. It wraps from NINPUTS-1 to 0.
- retry_cnt saturates at MAX_RETRY.
- enable low: all registers hold; flit_ack is still driven from held state.
- Asynchronous reset mid-timestep discards all inspection history immediately.

## Structure
- FLIT_WIDTH default and source-field position constants live in the shared const include. CLogB2 comes from the shared math include.
- Sub-module arbiter_rr: parameters SIZE and MODE; ports requests, pointer, grants, grant_valid. The input stage keeps the pointer register.
- Reuses the existing encoder_N and mux_Nto1 blocks.

## Test plan
- Reset then static mode: flit_in_valid=10'b0000010100 → grant input 2, s1_flit_iport=2, source field=2. Next cycle with enable, grant input 4. Then can_increment=1 after the s2 flit routes.
- Round-robin: all 10 valid, ticks every 10 cycles → grants 0..9 in order. After tick, grant 0 (rr_ptr wrapped). Second timestep starting with rr_ptr=3 grants 3..9,0..2.
- Ack: s2_flit_valid=1, s2_flit_routed=1, s2 input 7 → flit_ack=10'b0010000000 for exactly that cycle. Routed=0 → flit_ack=0.
- Retry: MAX_RETRY=2, single valid input 5, never routed → input 5 re-granted twice, then retry_exhausted=1 and can_increment=1 once s2 clears. Tick → retry_exhausted=0.
- Simultaneous tick and enable with grant pending → inspected=0 afterward.
- enable low for 5 cycles → no state change.
- Async reset asserted mid-cycle clears s2_flit_iport_decoded without a clock edge.

Source files
------------

// File: rtl/router_input_rr_pkg.sv
// Shared definitions for the router input stage.
//   - Default flit width and source-field position.
//   - Arbitration mode encoding.
//   - clogb2: number of bits needed to represent a value (clogb2(0) = 0).
package router_input_rr_pkg;

  localparam int FLIT_WIDTH_DEF = 36;
  localparam int SRC_LSB_DEF    = 2;

  typedef enum logic {
    ARB_STATIC = 1'b0,
    ARB_RR     = 1'b1
  } arb_mode_e;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/router_input_rr_arbiter_rr.sv
// One-hot arbiter used by the router input stage.
//   MODE 0 : lowest set request wins.
//   MODE 1 : first set request at or above 'pointer' wins, wrapping to index 0.
// Ports:
//   requests    in  SIZE   request vector
//   pointer     in  PTR_W  round-robin start index (owned by the caller)
//   grants      out SIZE   one-hot grant (zero when no request)
//   grant_valid out 1      any request present
module arbiter_rr
  import router_input_rr_pkg::*;
#(
  parameter int SIZE = 10,
  parameter int MODE = 1,
  localparam int PTR_W = clogb2(SIZE - 1)
) (
  input  logic [SIZE-1:0]  requests,
  input  logic [PTR_W-1:0] pointer,
  output logic [SIZE-1:0]  grants,
  output logic             grant_valid
);

  localparam bit RR_EN = (MODE == int'(ARB_RR));

  logic [SIZE-1:0] upper_mask;
  logic [SIZE-1:0] upper_req;
  logic [SIZE-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_mask
      assign upper_mask[gi] = RR_EN && (PTR_W'(gi) >= pointer);
    end
  endgenerate

  // Requests at/above the pointer take precedence; if none, wrap to the
  // full vector. Isolating the lowest set bit then yields the grant.
  assign upper_req   = requests & upper_mask;
  assign pick        = (|upper_req) ? upper_req : requests;
  assign grants      = pick & (~pick + SIZE'(1));
  assign grant_valid = |requests;

endmodule

// File: rtl/router_input_rr.sv
// Router input stage: picks one head flit per cycle from NPORTS*NVCS input
// queues, rewrites its source field with {port, vc}, tracks which inputs were
// already inspected this timestep, and acknowledges the source queue once
// stage 2 reports the flit routed. Unrouted flits may be re-offered up to
// MAX_RETRY times per timestep.
// Ports:
//   clock, reset (async, active-low), enable, sim_time_tick
//   flit_in / flit_in_valid          per-input head flits
//   s2_flit_valid / s2_flit_routed   stage-2 status
//   s1_flit, s1_flit_valid, s1_flit_iport   combinational selection
//   s2_flit_iport_decoded            registered one-hot stage-2 input
//   flit_ack                         one-hot dequeue
//   can_increment, retry_exhausted   timestep status
module router_input_rr
  import router_input_rr_pkg::*;
#(
  parameter int NPORTS     = 5,
  parameter int NVCS       = 2,
  parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
  parameter int SRC_LSB    = SRC_LSB_DEF,
  parameter int ARB_MODE   = 1,
  parameter int MAX_RETRY  = 3,
  localparam int NINPUTS     = NPORTS * NVCS,
  localparam int LOG_NINPUTS = clogb2(NPORTS - 1) + clogb2(NVCS - 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sim_time_tick,
  input  logic [NINPUTS*FLIT_WIDTH-1:0] flit_in,
  input  logic [NINPUTS-1:0]            flit_in_valid,
  input  logic                          s2_flit_valid,
  input  logic                          s2_flit_routed,
  output logic [FLIT_WIDTH-1:0]         s1_flit,
  output logic                          s1_flit_valid,
  output logic [LOG_NINPUTS-1:0]        s1_flit_iport,
  output logic [NINPUTS-1:0]            s2_flit_iport_decoded,
  output logic [NINPUTS-1:0]            flit_ack,
  output logic                          can_increment,
  output logic                          retry_exhausted
);

  localparam int LOG_P = clogb2(NPORTS - 1);
  localparam int LOG_V = clogb2(NVCS - 1);
  localparam int IDX_W = clogb2(NINPUTS - 1);
  localparam int CNT_W = (MAX_RETRY > 0) ? clogb2(MAX_RETRY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NINPUTS - 1);

  logic [NINPUTS-1:0]     inspected_reg;
  logic [NINPUTS-1:0]     s2_sel_reg;
  logic [IDX_W-1:0]       rr_ptr_reg;
  logic [CNT_W-1:0]       retry_cnt_reg;

  logic [NINPUTS-1:0]     eligible;
  logic [NINPUTS-1:0]     grant;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [LOG_NINPUTS-1:0] grant_src;
  logic                   retry_en;
  logic [NINPUTS-1:0]     retry_clear;
  logic [FLIT_WIDTH-1:0]  flit_arr [NINPUTS];
  logic [FLIT_WIDTH-1:0]  sel_flit;

  assign eligible = flit_in_valid & ~inspected_reg;

  arbiter_rr #(
    .SIZE (NINPUTS),
    .MODE (ARB_MODE)
  ) u_arb (
    .requests    (eligible),
    .pointer     (rr_ptr_reg),
    .grants      (grant),
    .grant_valid (grant_valid)
  );

  // One-hot to flat index (for the pointer) and to {port, vc} (for the
  // source field). Both stay zero when there is no grant.
  always_comb begin
    grant_idx = '0;
    grant_src = '0;
    for (int i = 0; i < NINPUTS; i++) begin
      if (grant[i]) begin
        grant_idx = grant_idx | IDX_W'(i);
        grant_src = grant_src | {LOG_P'(i / NVCS), LOG_V'(i % NVCS)};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NINPUTS; gi++) begin : g_slice
      assign flit_arr[gi] = flit_in[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

  assign sel_flit = flit_arr[grant_idx];

  // With no grant the index is zero, so input 0 passes through untouched.
  always_comb begin
    s1_flit = sel_flit;
    if (grant_valid) begin
      s1_flit[SRC_LSB +: LOG_NINPUTS] = grant_src;
    end
  end

  assign s1_flit_valid = grant_valid;
  assign s1_flit_iport = grant_src;

  // An unrouted stage-2 flit is handed back to arbitration while budget lasts.
  assign retry_en    = enable & s2_flit_valid & ~s2_flit_routed & (retry_cnt_reg < CNT_MAX);
  assign retry_clear = retry_en ? s2_sel_reg : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inspected_reg <= '0;
      s2_sel_reg    <= '0;
      rr_ptr_reg    <= '0;
      retry_cnt_reg <= '0;
    end else begin
      if (enable) begin
        s2_sel_reg <= grant;
        if (grant_valid) begin
          rr_ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
      end
      // A new timestep wipes inspection history and the retry budget even
      // while the pipeline is stalled.
      if (sim_time_tick) begin
        inspected_reg <= '0;
        retry_cnt_reg <= '0;
      end else if (enable) begin
        inspected_reg <= (inspected_reg | grant) & ~retry_clear;
        if (retry_en) begin
          retry_cnt_reg <= retry_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign s2_flit_iport_decoded = s2_sel_reg;
  assign flit_ack        = (s2_flit_valid & s2_flit_routed) ? s2_sel_reg : '0;
  assign can_increment   = ~(|eligible) & ~s2_flit_valid;
  assign retry_exhausted = (MAX_RETRY > 0) && (retry_cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_router_input_rr.sv
module tb_router_input_rr;

  localparam int NP   = 5;
  localparam int NV   = 2;
  localparam int NIN  = NP * NV;
  localparam int FW   = 36;
  localparam int SL   = 2;
  localparam int LOGN = 4;
  localparam int MAXR = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              sim_time_tick;
  logic [NIN*FW-1:0] flit_in;
  logic [NIN-1:0]    flit_in_valid;
  logic              s2_flit_valid;
  logic              s2_flit_routed;
  logic [FW-1:0]     flits [NIN];

  logic [FW-1:0]   rr_flit,  st_flit;
  logic            rr_valid, st_valid;
  logic [LOGN-1:0] rr_iport, st_iport;
  logic [NIN-1:0]  rr_s2dec, st_s2dec;
  logic [NIN-1:0]  rr_ack,   st_ack;
  logic            rr_caninc, st_caninc;
  logic            rr_rexh,   st_rexh;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always_comb begin
    flit_in = '0;
    for (int k = 0; k < NIN; k++) flit_in[k*FW +: FW] = flits[k];
  end

  router_input_rr #(.NPORTS(NP), .NVCS(NV), .FLIT_WIDTH(FW), .SRC_LSB(SL),
                    .ARB_MODE(1), .MAX_RETRY(MAXR)) dut_rr (
    .clock(clock), .reset(reset), .enable(enable), .sim_time_tick(sim_time_tick),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .s2_flit_valid(s2_flit_valid), .s2_flit_routed(s2_flit_routed),
    .s1_flit(rr_flit), .s1_flit_valid(rr_valid), .s1_flit_iport(rr_iport),
    .s2_flit_iport_decoded(rr_s2dec), .flit_ack(rr_ack),
    .can_increment(rr_caninc), .retry_exhausted(rr_rexh));

  router_input_rr #(.NPORTS(NP), .NVCS(NV), .FLIT_WIDTH(FW), .SRC_LSB(SL),
                    .ARB_MODE(0), .MAX_RETRY(MAXR)) dut_st (
    .clock(clock), .reset(reset), .enable(enable), .sim_time_tick(sim_time_tick),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .s2_flit_valid(s2_flit_valid), .s2_flit_routed(s2_flit_routed),
    .s1_flit(st_flit), .s1_flit_valid(st_valid), .s1_flit_iport(st_iport),
    .s2_flit_iport_decoded(st_s2dec), .flit_ack(st_ack),
    .can_increment(st_caninc), .retry_exhausted(st_rexh));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One cycle: inputs change at the falling edge, outputs sampled 1 time unit later.
  task automatic setin(input logic [NIN-1:0] v, input logic en, input logic tk,
                       input logic a, input logic b);
    @(negedge clock);
    flit_in_valid  = v;
    enable         = en;
    sim_time_tick  = tk;
    s2_flit_valid  = a;
    s2_flit_routed = b;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [FW-1:0] exp_flit(input int g);
    logic [FW-1:0] f;
    if (g < 0) return flits[0];
    f = flits[g];
    f[SL +: LOGN] = LOGN'(g);
    return f;
  endfunction

  // Reference model state: what has been looked at, who sits in stage 2,
  // where round-robin resumes, and how many retries were spent.
  logic [NIN-1:0] m_insp;
  logic [NIN-1:0] m_s2;
  int             m_ptr;
  int             m_cnt;

  function automatic int model_grant(input logic [NIN-1:0] elig, input int ptr);
    for (int k = 0; k < NIN; k++) begin
      int j;
      j = (ptr + k) % NIN;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_cycle();
    logic [NIN-1:0] elig;
    logic [NIN-1:0] gv;
    logic [63:0]    r64;
    logic [NIN-1:0] ack_exp;
    int             g;
    bit             clr;
    @(negedge clock);
    for (int k = 0; k < NIN; k++) begin
      r64 = {$urandom, $urandom};
      flits[k] = r64[FW-1:0];
    end
    flit_in_valid  = NIN'($urandom);
    enable         = ($urandom_range(0, 3) != 0);
    sim_time_tick  = ($urandom_range(0, 11) == 0);
    s2_flit_valid  = ($urandom_range(0, 9) < 7);
    s2_flit_routed = ($urandom_range(0, 1) == 1);
    #1;
    elig = flit_in_valid & ~m_insp;
    g = model_grant(elig, m_ptr);
    ack_exp = (s2_flit_valid && s2_flit_routed) ? m_s2 : '0;
    check("rnd_valid",  64'(rr_valid),  64'(g >= 0));
    check("rnd_iport",  64'(rr_iport),  (g >= 0) ? 64'(g) : 64'(0));
    check("rnd_flit",   64'(rr_flit),   64'(exp_flit(g)));
    check("rnd_s2dec",  64'(rr_s2dec),  64'(m_s2));
    check("rnd_ack",    64'(rr_ack),    64'(ack_exp));
    check("rnd_caninc", 64'(rr_caninc), 64'((elig == '0) && !s2_flit_valid));
    check("rnd_rexh",   64'(rr_rexh),   64'(m_cnt == MAXR));
    // advance model to the state after the coming rising edge
    gv  = (g >= 0) ? (NIN'(1) << g) : '0;
    clr = enable && s2_flit_valid && !s2_flit_routed && (m_cnt < MAXR);
    if (sim_time_tick) begin
      m_insp = '0;
      m_cnt  = 0;
    end else if (enable) begin
      m_insp = (m_insp | gv) & ~(clr ? m_s2 : '0);
      if (clr) m_cnt++;
    end
    if (enable) begin
      m_s2 = gv;
      if (g >= 0) m_ptr = (g + 1) % NIN;
    end
  endtask

  typedef struct {
    logic [NIN-1:0]  valid;
    logic            exp_valid;
    logic [LOGN-1:0] exp_iport;
    logic            exp_caninc;
  } vec_t;

  vec_t vecs [6];

  localparam logic [NIN-1:0] ALL = '1;
  localparam logic [NIN-1:0] B5  = 10'b0000100000;
  localparam logic [NIN-1:0] B7  = 10'b0010000000;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10'b0000000000, 1'b0, 4'd0, 1'b1};
    vecs[1] = '{10'b0000010100, 1'b1, 4'd2, 1'b0};
    vecs[2] = '{10'b1000000000, 1'b1, 4'd9, 1'b0};
    vecs[3] = '{10'b0000000001, 1'b1, 4'd0, 1'b0};
    vecs[4] = '{10'b0110000000, 1'b1, 4'd7, 1'b0};
    vecs[5] = '{10'b1111111110, 1'b1, 4'd1, 1'b0};
    for (int k = 0; k < NIN; k++) flits[k] = {4'h9, 16'(k * 257), 16'hFFFF};

    // Reset state with stage 2 claiming a routed flit: no ack may appear.
    reset = 1'b0; enable = 1'b0; sim_time_tick = 1'b0;
    s2_flit_valid = 1'b1; s2_flit_routed = 1'b1; flit_in_valid = ALL;
    repeat (2) @(posedge clock);
    #1;
    check("rst_s2dec", 64'(rr_s2dec), 64'(0));
    check("rst_ack",   64'(rr_ack),   64'(0));
    check("rst_rexh",  64'(rr_rexh),  64'(0));
    check("rst_s1val", 64'(rr_valid), 64'(1));
    check("rst_iport", 64'(rr_iport), 64'(0));
    @(negedge clock);
    reset = 1'b1; s2_flit_valid = 1'b0; s2_flit_routed = 1'b0;

    // Table: combinational selection with the pipeline stalled.
    for (int i = 0; i < 6; i++) begin
      setin(vecs[i].valid, 1'b0, 1'b0, 1'b0, 1'b0);
      check("tbl_st_valid",  64'(st_valid),  64'(vecs[i].exp_valid));
      check("tbl_st_iport",  64'(st_iport),  64'(vecs[i].exp_iport));
      check("tbl_rr_iport",  64'(rr_iport),  64'(vecs[i].exp_iport));
      check("tbl_st_caninc", 64'(st_caninc), 64'(vecs[i].exp_caninc));
      check("tbl_st_flit",   64'(st_flit),
            64'(exp_flit(vecs[i].exp_valid ? int'(vecs[i].exp_iport) : -1)));
    end
    check("tbl_hold_s2", 64'(st_s2dec), 64'(0));

    // Static mode: inputs 2 and 4 in turn, then acks and timestep advance.
    setin(10'b0000010100, 1'b1, 1'b0, 1'b0, 1'b0);
    check("st_g2",      64'(st_iport),        64'(2));
    check("st_g2_src",  64'(st_flit[SL +: LOGN]), 64'(2));
    setin(10'b0000010100, 1'b1, 1'b0, 1'b1, 1'b1);
    check("st_g4",      64'(st_iport),        64'(4));
    check("st_ack2",    64'(st_ack),          64'(10'b0000000100));
    setin(10'b0000010100, 1'b1, 1'b0, 1'b1, 1'b1);
    check("st_none",    64'(st_valid),        64'(0));
    check("st_busy",    64'(st_caninc),       64'(0));
    check("st_ack4",    64'(st_ack),          64'(10'b0000010000));
    setin(10'b0000010100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("st_caninc",  64'(st_caninc),       64'(1));

    // Acknowledge of stage-2 input 7 (round-robin pointer sits at 5).
    setin(B7, 1'b0, 1'b1, 1'b0, 1'b0);
    setin(B7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ack_g7",     64'(rr_iport), 64'(7));
    setin('0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ack_7",      64'(rr_ack),   64'(B7));
    check("ack_s2dec",  64'(rr_s2dec), 64'(B7));
    setin('0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ack_unrtd",  64'(rr_ack),   64'(0));
    setin('0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_nos2",   64'(rr_ack),   64'(0));

    // Asynchronous reset between clock edges.
    s2_flit_valid = 1'b1; s2_flit_routed = 1'b1;
    #1;
    check("arst_pre",   64'(rr_ack),   64'(B7));
    reset = 1'b0;
    #1;
    check("arst_s2dec", 64'(rr_s2dec), 64'(0));
    check("arst_ack",   64'(rr_ack),   64'(0));
    @(negedge clock);
    reset = 1'b1; s2_flit_valid = 1'b0; s2_flit_routed = 1'b0;

    // Round-robin over all ten inputs, wrap, then a timestep starting at 3.
    for (int k = 0; k < NIN; k++) begin
      setin(ALL, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rr_seq0", 64'(rr_iport), 64'(k));
    end
    setin(ALL, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rr_empty",  64'(rr_valid),  64'(0));
    check("rr_caninc", 64'(rr_caninc), 64'(1));
    setin(ALL, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      setin(ALL, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rr_wrap", 64'(rr_iport), 64'(k));
    end
    setin(ALL, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NIN; k++) begin
      setin(ALL, 1'b1, 1'b0, 1'b0, 1'b0);
      check("rr_seq3", 64'((3 + k) % NIN), 64'(rr_iport));
    end

    // Tick together with an enabled grant: inspection history still clears.
    setin(ALL, 1'b0, 1'b1, 1'b0, 1'b0);
    setin(ALL, 1'b1, 1'b1, 1'b0, 1'b0);
    check("tick_en_g0", 64'(st_iport), 64'(0));
    setin(ALL, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tick_en_re", 64'(st_iport), 64'(0));

    // Retry budget of two on a single never-routed input.
    pulse_reset();
    setin(B5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_g5a",   64'(rr_iport), 64'(5));
    setin(B5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rt_nog1",  64'(rr_valid), 64'(0));
    setin(B5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_g5b",   64'(rr_valid), 64'(1));
    check("rt_g5b_i", 64'(rr_iport), 64'(5));
    setin(B5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rt_rexh0", 64'(rr_rexh),  64'(0));
    setin(B5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_g5c",   64'(rr_iport), 64'(5));
    check("rt_rexh1", 64'(rr_rexh),  64'(1));
    setin(B5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rt_nog3",  64'(rr_valid), 64'(0));
    check("rt_busy",  64'(rr_caninc), 64'(0));
    setin(B5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rt_stuck", 64'(rr_valid), 64'(0));
    check("rt_caninc", 64'(rr_caninc), 64'(1));
    check("rt_rexh2", 64'(rr_rexh),  64'(1));
    setin(B5, 1'b0, 1'b1, 1'b0, 1'b0);
    setin(B5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rt_tick",  64'(rr_rexh),  64'(0));
    check("rt_fresh", 64'(rr_iport), 64'(5));

    // Stall for five cycles with a retry-worthy condition present.
    setin(B5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      setin(B5, 1'b0, 1'b0, 1'b1, 1'b0);
      check("hold_s2",   64'(rr_s2dec), 64'(B5));
      check("hold_rexh", 64'(rr_rexh),  64'(0));
    end
    setin(B5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_insp", 64'(rr_valid), 64'(0));

    // Randomized run against the reference model.
    pulse_reset();
    m_insp = '0; m_s2 = '0; m_ptr = 0; m_cnt = 0;
    for (int n = 0; n < 1500; n++) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
